// File: rtl/vga_pattern_cmd_ctrl_if.sv
// rtl/vga_pattern_cmd_ctrl_if.sv - UART RX/TX byte handshake bundle for the pattern command controller
interface vga_pattern_cmd_ctrl_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       i_TX_Active;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;

  modport slave  (input  i_RX_DV, i_RX_Byte, i_TX_Active, output o_TX_DV, o_TX_Byte);
  modport master (output i_RX_DV, i_RX_Byte, i_TX_Active, input  o_TX_DV, o_TX_Byte);
endinterface

// File: rtl/vga_pattern_cmd_ctrl.sv
// rtl/vga_pattern_cmd_ctrl.sv - UART command parser with frame-synchronous pattern/colour registers
// Optional one-byte legacy pattern commands: VGA_PATTERN_CMD_LEGACY_EN.
module vga_pattern_cmd_ctrl #(
  parameter int         VIDEO_WIDTH  = 3,
  parameter int         NUM_PATTERNS = 8,
  parameter int         TIMEOUT_CLKS = 25000000,
  parameter logic [7:0] ACK_BYTE     = 8'h06,
  parameter logic [7:0] NAK_BYTE     = 8'h15
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  vga_pattern_cmd_ctrl_if.slave  uart,
  input  logic                   i_Frame_Start,
  output logic [3:0]             o_Pattern,
  output logic [VIDEO_WIDTH-1:0] o_Solid_Red,
  output logic [VIDEO_WIDTH-1:0] o_Solid_Grn,
  output logic [VIDEO_WIDTH-1:0] o_Solid_Blu,
  output logic [7:0]             o_Cmd_Err_Count
);

  localparam logic [7:0]      CMD_PAT = 8'h50;
  localparam logic [7:0]      CMD_COL = 8'h43;
  localparam int              TO_W    = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [4:0]      NPAT    = 5'(NUM_PATTERNS);

  typedef enum logic [2:0] {S_IDLE, S_GET_PAT, S_GET_R, S_GET_G, S_GET_B} state_t;

  state_t                 r_state, w_next;
  logic [TO_W-1:0]        r_to_cnt;
  logic [VIDEO_WIDTH-1:0] r_cap_r, r_cap_g;
  logic [3:0]             r_pend_pat, r_pattern;
  logic [VIDEO_WIDTH-1:0] r_pend_r, r_pend_g, r_pend_b;
  logic [VIDEO_WIDTH-1:0] r_red, r_grn, r_blu;
  logic                   r_resp_pend, r_tx_dv;
  logic [7:0]             r_resp_byte, r_tx_byte, r_err_cnt;

  logic                   w_timeout, w_idx_ok, w_ack, w_nak, w_launch;
  logic                   w_commit_pat, w_commit_col, w_cap_r, w_cap_g;
  logic [VIDEO_WIDTH-1:0] w_chan;

  // A byte arriving on the expiry clock wins over the timeout.
  assign w_timeout = (r_state != S_IDLE) && !uart.i_RX_DV && (r_to_cnt == TO_LAST);
  assign w_idx_ok  = (uart.i_RX_Byte[7:4] == 4'h0) && ({1'b0, uart.i_RX_Byte[3:0]} < NPAT);
  assign w_chan    = uart.i_RX_Byte[7 -: VIDEO_WIDTH];

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_ack        = 1'b0;
    w_nak        = 1'b0;
    w_commit_pat = 1'b0;
    w_commit_col = 1'b0;
    w_cap_r      = 1'b0;
    w_cap_g      = 1'b0;
    if (w_timeout) begin
      w_next = S_IDLE;
      w_nak  = 1'b1;
    end else if (uart.i_RX_DV) begin
      case (r_state)
        S_IDLE: begin
          if (uart.i_RX_Byte == CMD_PAT)      w_next = S_GET_PAT;
          else if (uart.i_RX_Byte == CMD_COL) w_next = S_GET_R;
`ifdef VGA_PATTERN_CMD_LEGACY_EN
          else if (w_idx_ok) begin
            w_commit_pat = 1'b1;
            w_ack        = 1'b1;
          end
`endif
          else                                w_nak  = 1'b1;
        end
        S_GET_PAT: begin
          w_next       = S_IDLE;
          w_commit_pat = w_idx_ok;
          w_ack        = w_idx_ok;
          w_nak        = !w_idx_ok;
        end
        S_GET_R: begin
          w_cap_r = 1'b1;
          w_next  = S_GET_G;
        end
        S_GET_G: begin
          w_cap_g = 1'b1;
          w_next  = S_GET_B;
        end
        S_GET_B: begin
          w_commit_col = 1'b1;
          w_ack        = 1'b1;
          w_next       = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)                                             r_to_cnt <= '0;
    else if (uart.i_RX_DV || r_state == S_IDLE || w_timeout) r_to_cnt <= '0;
    else                                                      r_to_cnt <= r_to_cnt + 1'b1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_cap_r    <= '0;
      r_cap_g    <= '0;
      r_pend_pat <= '0;
      r_pend_r   <= '0;
      r_pend_g   <= '0;
      r_pend_b   <= '0;
    end else begin
      if (w_cap_r)      r_cap_r    <= w_chan;
      if (w_cap_g)      r_cap_g    <= w_chan;
      if (w_commit_pat) r_pend_pat <= uart.i_RX_Byte[3:0];
      if (w_commit_col) begin
        r_pend_r <= r_cap_r;
        r_pend_g <= r_cap_g;
        r_pend_b <= w_chan;
      end
    end
  end

  // Active registers sample the pending set as it stood before this edge,
  // so a same-cycle commit waits for the following frame.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_pattern <= '0;
      r_red     <= '0;
      r_grn     <= '0;
      r_blu     <= '0;
    end else if (i_Frame_Start) begin
      r_pattern <= r_pend_pat;
      r_red     <= r_pend_r;
      r_grn     <= r_pend_g;
      r_blu     <= r_pend_b;
    end
  end

  assign w_launch = r_resp_pend && !uart.i_TX_Active && !r_tx_dv;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_resp_pend <= 1'b0;
      r_resp_byte <= '0;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_tx_dv <= w_launch;
      if (w_launch) r_tx_byte <= r_resp_byte;
      if (w_ack || w_nak) begin
        r_resp_pend <= 1'b1;
        r_resp_byte <= w_ack ? ACK_BYTE : NAK_BYTE;
      end else if (w_launch) begin
        r_resp_pend <= 1'b0;
      end
      if (w_nak && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign uart.o_TX_DV    = r_tx_dv;
  assign uart.o_TX_Byte  = r_tx_byte;
  assign o_Pattern       = r_pattern;
  assign o_Solid_Red     = r_red;
  assign o_Solid_Grn     = r_grn;
  assign o_Solid_Blu     = r_blu;
  assign o_Cmd_Err_Count = r_err_cnt;

endmodule

// File: tb/tb_vga_pattern_cmd_ctrl.sv
// tb/tb_vga_pattern_cmd_ctrl.sv - self-checking bench for vga_pattern_cmd_ctrl
module tb_vga_pattern_cmd_ctrl;
  localparam int VW   = 3;
  localparam int NPAT = 8;
  localparam int TOC  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic [3:0]    o_pat;
  logic [VW-1:0] o_r, o_g, o_b;
  logic [7:0]    o_err;

  vga_pattern_cmd_ctrl_if bus ();

  vga_pattern_cmd_ctrl #(.VIDEO_WIDTH(VW), .NUM_PATTERNS(NPAT), .TIMEOUT_CLKS(TOC),
                         .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .uart(bus), .i_Frame_Start(frame_start),
    .o_Pattern(o_pat), .o_Solid_Red(o_r), .o_Solid_Grn(o_g), .o_Solid_Blu(o_b),
    .o_Cmd_Err_Count(o_err));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_b2b = 0;
  logic prev_dv = 1'b0;
  logic [7:0] tx_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.o_TX_DV) begin
      tx_q.push_back(bus.o_TX_Byte);
      if (prev_dv) n_b2b <= n_b2b + 1;
    end
    prev_dv <= rst_n && bus.o_TX_DV;
  end

  logic [3:0]    mp_pat, ma_pat;
  logic [VW-1:0] mp_r, mp_g, mp_b, ma_r, ma_g, ma_b;
  logic [7:0]    m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_pat"}, 32'(o_pat), 32'(ma_pat));
    chk({tag, "_red"}, 32'(o_r), 32'(ma_r));
    chk({tag, "_grn"}, 32'(o_g), 32'(ma_g));
    chk({tag, "_blu"}, 32'(o_b), 32'(ma_b));
    chk({tag, "_err"}, 32'(o_err), 32'(m_err));
  endtask

  // Reference: decode a whole command from its bytes and apply it to the pending set.
  function automatic logic [7:0] model_cmd(input logic [7:0] b0, b1, b2, b3);
    logic ok;
    ok = 1'b1;
    if (b0 == 8'h50) begin
      ok = int'(b1) < NPAT;
      if (ok) mp_pat = b1[3:0];
    end else if (b0 == 8'h43) begin
      mp_r = VW'(b1 >> (8 - VW));
      mp_g = VW'(b2 >> (8 - VW));
      mp_b = VW'(b3 >> (8 - VW));
    end else begin
`ifdef VGA_PATTERN_CMD_LEGACY_EN
      ok = int'(b0) < NPAT;
      if (ok) mp_pat = b0[3:0];
`else
      ok = 1'b0;
`endif
    end
    if (!ok) m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
    return ok ? 8'h06 : 8'h15;
  endfunction

  function automatic int cmd_len(input logic [7:0] b0);
    return (b0 == 8'h50) ? 2 : (b0 == 8'h43) ? 4 : 1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.i_RX_DV = 1'b1;
    bus.i_RX_Byte = b;
    @(posedge clk); #1;
    bus.i_RX_DV = 1'b0;
    bus.i_RX_Byte = $urandom_range(0, 255);
  endtask

  task automatic send_cmd(input logic [31:0] cmd);
    for (int i = 0; i < cmd_len(cmd[31:24]); i++) begin
      send_byte(cmd[31 - 8*i -: 8]);
      idle($urandom_range(0, 3));
    end
  endtask

  task automatic expect_resp(input string nm, input logic [7:0] exp);
    int k;
    k = 0;
    while (tx_q.size() == 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (tx_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no response byte within 200 clocks, expected %0h", nm, exp);
    end else begin
      chk(nm, 32'(tx_q.pop_front()), 32'(exp));
    end
  endtask

  task automatic frame();
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    ma_pat = mp_pat; ma_r = mp_r; ma_g = mp_g; ma_b = mp_b;
  endtask

  typedef struct packed {
    logic [31:0]   cmd;
    logic [7:0]    resp;
    logic [3:0]    pat;
    logic [VW-1:0] r, g, b;
    logic [7:0]    err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] b0, b1, b2, b3, exp;
    int k;
    tbl[0] = '{32'h5005_0000, 8'h06, 4'd5, 3'd0, 3'd0, 3'd0, 8'd0};
    tbl[1] = '{32'h43FF_8020, 8'h06, 4'd5, 3'd7, 3'd4, 3'd1, 8'd0};
    tbl[2] = '{32'h500A_0000, 8'h15, 4'd5, 3'd7, 3'd4, 3'd1, 8'd1};
    tbl[3] = '{32'h5A00_0000, 8'h15, 4'd5, 3'd7, 3'd4, 3'd1, 8'd2};
    tbl[4] = '{32'h5007_0000, 8'h06, 4'd7, 3'd7, 3'd4, 3'd1, 8'd2};
    tbl[5] = '{32'h5008_0000, 8'h15, 4'd7, 3'd7, 3'd4, 3'd1, 8'd3};
    tbl[6] = '{32'h5017_0000, 8'h15, 4'd7, 3'd7, 3'd4, 3'd1, 8'd4};
    tbl[7] = '{32'h4300_0000, 8'h06, 4'd7, 3'd0, 3'd0, 3'd0, 8'd4};
`ifdef VGA_PATTERN_CMD_LEGACY_EN
    tbl[8] = '{32'h0300_0000, 8'h06, 4'd3, 3'd0, 3'd0, 3'd0, 8'd4};
`else
    tbl[8] = '{32'h0300_0000, 8'h15, 4'd7, 3'd0, 3'd0, 3'd0, 8'd5};
`endif

    bus.i_RX_DV = 1'b0;
    bus.i_RX_Byte = 8'h00;
    bus.i_TX_Active = 1'b0;
    mp_pat = '0; ma_pat = '0; mp_r = '0; mp_g = '0; mp_b = '0;
    ma_r = '0; ma_g = '0; ma_b = '0; m_err = '0;

    idle(3);
    chk_outs("reset");
    rst_n = 1'b1;
    frame();
    idle(4);
    frame();
    chk_outs("post_reset_frames");
    chk("post_reset_no_tx", 32'(tx_q.size()), 32'd0);

    for (int i = 0; i < 9; i++) begin
      send_cmd(tbl[i].cmd);
      expect_resp($sformatf("tbl%0d_resp", i), tbl[i].resp);
      chk($sformatf("tbl%0d_pat_held", i), 32'(o_pat), 32'(ma_pat));
      frame();
      chk($sformatf("tbl%0d_pat", i), 32'(o_pat), 32'(tbl[i].pat));
      chk($sformatf("tbl%0d_red", i), 32'(o_r), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_grn", i), 32'(o_g), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_blu", i), 32'(o_b), 32'(tbl[i].b));
      chk($sformatf("tbl%0d_err", i), 32'(o_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_extra_tx", i), 32'(tx_q.size()), 32'd0);
      mp_pat = tbl[i].pat; mp_r = tbl[i].r; mp_g = tbl[i].g; mp_b = tbl[i].b;
      ma_pat = mp_pat; ma_r = mp_r; ma_g = mp_g; ma_b = mp_b;
      m_err = tbl[i].err;
    end

    // Commit on the same clock as a frame start lands one frame later.
    send_byte(8'h50);
    @(posedge clk); #1;
    bus.i_RX_DV = 1'b1; bus.i_RX_Byte = 8'h06; frame_start = 1'b1;
    @(posedge clk); #1;
    bus.i_RX_DV = 1'b0; frame_start = 1'b0;
    chk("same_edge_pat_held", 32'(o_pat), 32'(ma_pat));
    exp = model_cmd(8'h50, 8'h06, 8'h00, 8'h00);
    expect_resp("same_edge_resp", exp);
    frame();
    chk("same_edge_pat_next", 32'(o_pat), 32'd6);

    // Abandoned colour command times out.
    send_byte(8'h43);
    send_byte(8'h10);
    idle(TOC - 4);
    chk("timeout_not_early", 32'(tx_q.size()), 32'd0);
    m_err = m_err + 8'd1;
    expect_resp("timeout_nak", 8'h15);
    chk("timeout_err", 32'(o_err), 32'(m_err));
    exp = model_cmd(8'h50, 8'h02, 8'h00, 8'h00);
    send_cmd(32'h5002_0000);
    expect_resp("after_timeout_resp", exp);
    frame();
    chk_outs("after_timeout");
    chk("after_timeout_pat", 32'(o_pat), 32'd2);

    // Busy transmitter: two responses collapse into one carrying the latest byte.
    bus.i_TX_Active = 1'b1;
    exp = model_cmd(8'h50, 8'h01, 8'h00, 8'h00);
    send_cmd(32'h5001_0000);
    exp = model_cmd(8'h50, 8'h09, 8'h00, 8'h00);
    send_cmd(32'h5009_0000);
    idle(10);
    chk("busy_no_tx", 32'(tx_q.size()), 32'd0);
    bus.i_TX_Active = 1'b0;
    expect_resp("busy_last_resp", exp);
    idle(10);
    chk("busy_single_strobe", 32'(tx_q.size()), 32'd0);
    frame();
    chk_outs("busy");

    for (int i = 0; i < 60; i++) begin
      b0 = $urandom_range(0, 255);
      b1 = $urandom_range(0, 255);
      b2 = $urandom_range(0, 255);
      b3 = $urandom_range(0, 255);
      case ($urandom_range(0, 4))
        0: begin b0 = 8'h50; b1 = 8'($urandom_range(0, NPAT - 1)); end
        1: b0 = 8'h50;
        2: b0 = 8'h43;
        3: if (b0 == 8'h50 || b0 == 8'h43) b0 = b0 ^ 8'h01;
        default: b0 = 8'($urandom_range(0, 15));
      endcase
      exp = model_cmd(b0, b1, b2, b3);
      send_cmd({b0, b1, b2, b3});
      expect_resp("rand_resp", exp);
      chk("rand_err", 32'(o_err), 32'(m_err));
      if ($urandom_range(0, 1) == 1) begin
        frame();
        chk_outs("rand");
      end
    end

    // Reset in the middle of a command drops it silently.
    send_byte(8'h43);
    rst_n = 1'b0;
    #1;
    mp_pat = '0; ma_pat = '0; mp_r = '0; mp_g = '0; mp_b = '0;
    ma_r = '0; ma_g = '0; ma_b = '0; m_err = '0;
    chk_outs("mid_reset");
    idle(3);
    rst_n = 1'b1;
    idle(TOC + 20);
    chk("mid_reset_no_tx", 32'(tx_q.size()), 32'd0);
    frame();
    chk_outs("mid_reset_frame");

    k = 0;
    repeat (254) begin
      send_byte(8'hFF);
      k++;
    end
    chk("err_fe", 32'(o_err), 32'hFE);
    send_byte(8'hFF);
    chk("err_ff", 32'(o_err), 32'hFF);
    repeat (3) send_byte(8'hFF);
    chk("err_saturated", 32'(o_err), 32'hFF);
    chk("sat_cmd_count", 32'(k), 32'd254);
    idle(10);
    tx_q.delete();

    chk("tx_back_to_back", 32'(n_b2b), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_pattern_cmd_ctrl.md
Name: vga_pattern_cmd_ctrl

Overview:
- UART command parser and frame-synchronous register bank for the VGA test-pattern path.
- Sits between the UART_RX byte stream and Test_Pattern_Gen. Replaces the single-byte pattern latch with a multi-byte protocol: pattern select plus a programmable solid colour.
- Commands are validated and acknowledged over UART_TX. They take effect only at a frame boundary, so no frame is ever torn.

Parameters:
- VIDEO_WIDTH, 3, bits per colour channel on the solid-colour outputs.
- NUM_PATTERNS, 8, number of valid pattern indices (1..16); indices >= NUM_PATTERNS are rejected.
- TIMEOUT_CLKS, 25000000, max clocks between bytes of one command before abort (1 s at 25 MHz).
- ACK_BYTE, 8'h06, response byte for an accepted command.
- NAK_BYTE, 8'h15, response byte for a rejected or aborted command.

Ports:
- i_Clk  in  1  system clock (25 MHz pixel clock).
- i_Rst_L  in  1  asynchronous active-low reset.
- i_RX_DV  in  1  single-cycle byte-valid strobe from UART_RX.
- i_RX_Byte  in  8  received byte; valid only while i_RX_DV=1.
- i_Frame_Start  in  1  single-cycle pulse at the first clock of each frame.
- i_TX_Active  in  1  UART_TX busy flag.
- o_TX_DV  out  1  single-cycle strobe to UART_TX.
- o_TX_Byte  out  8  response byte; valid while o_TX_DV=1.
- o_Pattern  out  4  active pattern index.
- o_Solid_Red  out  VIDEO_WIDTH  active solid colour, red.
- o_Solid_Grn  out  VIDEO_WIDTH  active solid colour, green.
- o_Solid_Blu  out  VIDEO_WIDTH  active solid colour, blue.
- o_Cmd_Err_Count  out  8  saturating count of NAKs issued.

Behaviour:
- Reset (i_Rst_L=0, asynchronous) clears every output and internal register to 0, sets the FSM to IDLE and clears the response-pending flag.
- Protocol:
  - 'P' (8'h50) followed by index byte: index = byte[3:0]. Byte[7:4] must be 0 and the index must be < NUM_PATTERNS, else NAK.
  - 'C' (8'h43) followed by R, G, B bytes: each channel takes byte[7:8-VIDEO_WIDTH] (MSBs).
  - Any other first byte in IDLE: NAK.
- FSM states: IDLE, GET_PAT, GET_R, GET_G, GET_B.
  - IDLE: 'P' -> GET_PAT; 'C' -> GET_R; other byte -> NAK, stay IDLE.
  - GET_PAT: byte -> commit or NAK, then IDLE.
  - GET_R -> GET_G -> GET_B, each on a byte.
  - GET_B: byte -> commit colour, ACK, IDLE.
- Timeout: counter clears on every i_RX_DV and counts only outside IDLE. Reaching TIMEOUT_CLKS-1 -> NAK, IDLE, partial command discarded.
- Commit writes pending registers only. On i_Frame_Start, active outputs <= pending registers (value before any same-edge commit).
  - If a commit and i_Frame_Start fall in the same cycle, the new value appears at the following frame start.
  - Latency from commit to output: 1 clock after the next i_Frame_Start.
- Response slot (single entry):
  - A response sets pending. o_TX_DV pulses one cycle on the first clock with pending=1 and i_TX_Active=0, then pending clears.
  - A new response while pending overwrites the queued byte; no extra strobe is issued.
  - o_TX_DV is never asserted on two consecutive clocks.
- o_Cmd_Err_Count increments on every NAK and saturates at 8'hFF.
- Reset mid-command: all state is lost and no response is sent.

Optional Feature:
- Macro: VGA_PATTERN_CMD_LEGACY_EN.
- Defined: in IDLE, a byte with [7:4]=0 and [3:0] < NUM_PATTERNS is a one-byte pattern command. It commits and ACKs immediately, compatible with the existing terminal workflow. Such bytes never NAK.
- Undefined: these bytes NAK, as for any other unknown command byte.

Test Plan:
- Reset released, frame pulses only -> o_Pattern=0, colours 0, o_TX_DV never asserted, o_Cmd_Err_Count=0.
- Send 8'h50, 8'h05 mid-frame -> one ACK 8'h06 when i_TX_Active=0. o_Pattern holds 0 until the next i_Frame_Start, then reads 5.
- Send 8'h43, 8'hFF, 8'h80, 8'h20 (VIDEO_WIDTH=3) -> after the next frame start Red=3'b111, Grn=3'b100, Blu=3'b001; ACK once.
- Send 8'h50, 8'h0A (NUM_PATTERNS=8) -> NAK 8'h15, o_Pattern unchanged, o_Cmd_Err_Count=1. Send 8'h5A in IDLE -> NAK, count=2.
- Send 8'h43, 8'h10, then idle TIMEOUT_CLKS clocks -> NAK, FSM back in IDLE; a following 'P',8'h02 is ACKed and applied.
- Hold i_TX_Active=1 across two completed commands -> single o_TX_DV after release, carrying the second response byte. With VGA_PATTERN_CMD_LEGACY_EN defined, byte 8'h03 alone -> ACK and pattern 3 at the next frame.
